// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lock controller.
// State encodings are visible on the `state` output, so their values are fixed.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SET_AWAIT = 3'd1,
    ST_OPENED    = 3'd2,
    ST_ALARM     = 3'd3,
    ST_INPUT     = 3'd4,
    ST_LOCKOUT   = 3'd5
  } lock_state_t;

  localparam int BLINK_W  = 16;
  localparam int DB_CNT_W = 4;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stable-sample debouncer for one raw push-button.
// Emits a single-cycle pulse on an accepted press; releases must be equally stable.
module btn_debounce
  import lock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam logic [DB_CNT_W-1:0] CNT_TC = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_cfg
    $error("btn_debounce: DEBOUNCE_CYCLES out of range");
  end

  logic                sync1;
  logic                sync2;
  logic [1:0]          warm;
  logic                level;
  logic [DB_CNT_W-1:0] cnt;

  // level resets high so a button held through reset must be released first;
  // warm masks the two cycles where sync2 still holds reset values, not the pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      warm  <= 2'b00;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      warm  <= {warm[0], 1'b1};
      press <= 1'b0;
      if (!warm[1] || sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_TC) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lock_controller.sv
// Keypad lock sequencer: debounced buttons, code check, re-programming, alarm.
// Define LOCK_LOCKOUT_EN to add the timed lockout after MAX_TRIES failed codes.
//
// state      | meaning
// IDLE       | locked, waiting for enter to start code entry
// SET_AWAIT  | open, waiting for check to latch a new password
// OPENED     | correct code accepted, lock open
// ALARM      | wrong code, led blinking until enter
// INPUT      | code entry, enter compares, check cancels
// LOCKOUT    | too many failures, all presses ignored until timer expires
module lock_controller
  import lock_pkg::*;
#(
  parameter int PW_WIDTH        = 7,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_TRIES       = 3,
  parameter int LOCKOUT_CYCLES  = 256,
  parameter int BLINK_BIT       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_check,
  input  logic                btn_enter,
  input  logic [PW_WIDTH-1:0] code_in,
  output logic                opened,
  output logic                alarm_led,
  output logic [2:0]          state,
  output logic [1:0]          fails,
  output logic                lockout
);

  if (PW_WIDTH < 1 || MAX_TRIES < 1 || MAX_TRIES > 3 || LOCKOUT_CYCLES < 2 ||
      LOCKOUT_CYCLES > 65535 || BLINK_BIT < 0 || BLINK_BIT >= BLINK_W) begin : g_bad_cfg
    $error("lock_controller: parameter out of range");
  end

  lock_state_t         state_q;
  lock_state_t         state_d;
  logic                chk_p;
  logic                ent_raw_p;
  logic                ent_p;
  logic                code_ok;
  logic                pw_load;
  logic                fails_clr;
  logic                fails_inc;
  logic [PW_WIDTH-1:0] pw_q;
  logic [1:0]          fails_q;
  logic [BLINK_W-1:0]  blink_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_check (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_check),
    .press (chk_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_enter),
    .press (ent_raw_p)
  );

  // check has priority when both presses land in the same cycle
  assign ent_p   = ent_raw_p & ~chk_p;
  assign code_ok = (code_in == pw_q);

`ifdef LOCK_LOCKOUT_EN
  localparam logic [15:0] LOCK_TC   = 16'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]  TRIES_LIM = 2'(MAX_TRIES);

  logic [15:0] lock_tmr_q;
  logic        lock_done;
  logic        lock_hit;

  assign lock_hit  = (sat_inc2(fails_q) >= TRIES_LIM);
  assign lock_done = (lock_tmr_q == '0);

  // Loaded on the entry edge so the exit lands exactly LOCKOUT_CYCLES later.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_tmr_q <= '0;
    end else if (state_d == ST_LOCKOUT && state_q != ST_LOCKOUT) begin
      lock_tmr_q <= LOCK_TC;
    end else if (state_q == ST_LOCKOUT && !lock_done) begin
      lock_tmr_q <= lock_tmr_q - 16'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pw_load   = 1'b0;
    fails_clr = 1'b0;
    fails_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ent_p) state_d = ST_INPUT;
      end
      ST_INPUT: begin
        if (chk_p) begin
          state_d = ST_IDLE;
        end else if (ent_p) begin
          if (code_ok) begin
            state_d   = ST_OPENED;
            fails_clr = 1'b1;
          end else begin
            fails_inc = 1'b1;
            state_d   = ST_ALARM;
`ifdef LOCK_LOCKOUT_EN
            if (lock_hit) state_d = ST_LOCKOUT;
`endif
          end
        end
      end
      ST_OPENED: begin
        if (chk_p)      state_d = ST_SET_AWAIT;
        else if (ent_p) state_d = ST_IDLE;
      end
      ST_SET_AWAIT: begin
        if (chk_p) begin
          pw_load = 1'b1;
          state_d = ST_IDLE;
        end else if (ent_p) begin
          state_d = ST_IDLE;
        end
      end
      ST_ALARM: begin
        if (ent_p) state_d = ST_IDLE;
      end
`ifdef LOCK_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (lock_done) begin
          state_d   = ST_IDLE;
          fails_clr = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pw_q    <= '0;
      fails_q <= '0;
      blink_q <= '0;
    end else begin
      blink_q <= blink_q + 1'b1;
      if (pw_load) pw_q <= code_in;
      if (fails_clr)      fails_q <= '0;
      else if (fails_inc) fails_q <= sat_inc2(fails_q);
    end
  end

  always_comb begin
    state     = state_q;
    opened    = (state_q == ST_OPENED);
    lockout   = 1'b0;
    alarm_led = 1'b0;
`ifdef LOCK_LOCKOUT_EN
    lockout = (state_q == ST_LOCKOUT);
`endif
    if (state_q == ST_ALARM || state_q == ST_LOCKOUT) alarm_led = blink_q[BLINK_BIT];
  end

  assign fails = fails_q;

endmodule

// File: tb/tb_lock_controller.sv
// Scoreboard bench for lock_controller: expected state transitions are queued with
// their exact cycle, and a negedge monitor checks every state change against them.
module tb_lock_controller;

  localparam int D   = 4;
  localparam int LCK = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_check = 1'b0;
  logic       btn_enter = 1'b0;
  logic [6:0] code_in = '0;
  logic       opened;
  logic       alarm_led;
  logic [2:0] state;
  logic [1:0] fails;
  logic       lockout;

  lock_controller #(
    .PW_WIDTH(7), .DEBOUNCE_CYCLES(D), .MAX_TRIES(3),
    .LOCKOUT_CYCLES(LCK), .BLINK_BIT(8)
  ) dut (
    .clk(clk), .rst(rst), .btn_check(btn_check), .btn_enter(btn_enter),
    .code_in(code_in), .opened(opened), .alarm_led(alarm_led),
    .state(state), .fails(fails), .lockout(lockout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] st;
    logic       op;
    logic [1:0] fl;
    logic       lk;
    int         at;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         reset_cyc = 0;
  int         m_state = 0;
  logic [2:0] prev_state = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int st, input int fl, input int at);
    exp_t e;
    e.st = 3'(st);
    e.op = (st == 2);
    e.fl = 2'(fl);
    e.lk = (st == 5);
    e.at = at;
    sbq.push_back(e);
    m_state = st;
  endtask

  always @(negedge clk) begin
    if (!rst && state !== prev_state) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: state %0d (was %0d) at cycle %0d, none expected",
                 state, prev_state, cyc);
      end else begin
        mon_e = sbq.pop_front();
        if (state !== mon_e.st || opened !== mon_e.op || fails !== mon_e.fl ||
            lockout !== mon_e.lk || cyc != mon_e.at) begin
          errors++;
          $display("FAIL sb_transition: got state=%0d opened=%0d fails=%0d lockout=%0d cycle=%0d, expected state=%0d opened=%0d fails=%0d lockout=%0d cycle=%0d",
                   state, opened, fails, lockout, cyc,
                   mon_e.st, mon_e.op, mon_e.fl, mon_e.lk, mon_e.at);
        end
      end
    end
    prev_state = state;
  end

  // Raw edge driven after edge k is captured at k+1; the FSM moves at k+1+D+2.
  task automatic press(input bit chk, input bit ent, input logic [6:0] code,
                       input bit exp_chg, input int st, input int fl, output int at);
    @(posedge clk); #1;
    code_in   = code;
    btn_check = chk;
    btn_enter = ent;
    at = cyc + 1 + D + 2;
    if (exp_chg) push(st, fl, at);
    repeat (10) @(posedge clk);
    #1;
    btn_check = 1'b0;
    btn_enter = 1'b0;
    repeat (D + 6) @(posedge clk);
  endtask

  task automatic p(input bit chk, input bit ent, input logic [6:0] code,
                   input int st, input int fl);
    int at;
    press(chk, ent, code, 1'b1, st, fl, at);
  endtask

  task automatic pn(input bit chk, input bit ent, input logic [6:0] code);
    int at;
    press(chk, ent, code, 1'b0, 0, 0, at);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    if (m_state != 0) push(0, 0, cyc + 1);
    @(posedge clk); #1;
    rst = 1'b0;
    reset_cyc = cyc;
  endtask

  function automatic logic blink_model(input int c, input bit active);
    int unsigned d;
    d = 32'(c - reset_cyc) & 32'hFFFF;
    return active ? d[8] : 1'b0;
  endfunction

  task automatic check_blink(input string name, input int n, input bit active);
    int   bad = 0;
    int   tog_dut = 0;
    int   tog_mod = 0;
    logic pd, pm, md;
    @(negedge clk);
    pd = alarm_led;
    pm = blink_model(cyc, active);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      md = blink_model(cyc, active);
      if (alarm_led !== md) bad++;
      if (alarm_led !== pd) tog_dut++;
      if (md != pm) tog_mod++;
      pd = alarm_led;
      pm = md;
    end
    check({name, "_value_errors"}, bad, 0);
    if (active) check({name, "_toggles"}, tog_dut, tog_mod);
  endtask

  initial begin
    int at_e;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    reset_cyc = cyc;
    @(negedge clk);
    check("reset_state", state, 0);
    check("reset_opened", opened, 0);
    check("reset_fails", fails, 0);
    check("reset_lockout", lockout, 0);
    check("reset_alarm_led", alarm_led, 0);
    repeat (6) @(posedge clk);

    // default password 0x00, then program 0x5A
    p(0, 1, 7'h00, 4, 0);
    p(0, 1, 7'h00, 2, 0);
    p(1, 0, 7'h00, 1, 0);
    p(1, 0, 7'h5A, 0, 0);
    p(0, 1, 7'h5A, 4, 0);
    p(0, 1, 7'h5A, 2, 0);
    p(0, 1, 7'h5A, 0, 0);

    // wrong code, blink, ignored check, leave alarm
    p(0, 1, 7'h11, 4, 0);
    p(0, 1, 7'h11, 3, 1);
    check_blink("alarm_blink", 600, 1'b1);
    pn(1, 0, 7'h11);
    p(0, 1, 7'h11, 0, 1);
    check_blink("idle_led", 300, 1'b0);
    check("fails_after_alarm", fails, 1);

    // cancel from INPUT
    p(0, 1, 7'h00, 4, 1);
    p(1, 0, 7'h00, 0, 1);

    // 3-cycle glitch and a 1-0-1-0 bounce train must not register
    @(posedge clk); #1;
    btn_enter = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    btn_enter = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      btn_enter = (i % 2 == 0);
      @(posedge clk); #1;
    end
    btn_enter = 1'b0;
    repeat (12) @(posedge clk);
    check("glitch_no_change", state, 0);
    p(0, 1, 7'h00, 4, 1);
    p(1, 0, 7'h00, 0, 1);

    // second and third mismatches
    p(0, 1, 7'h22, 4, 1);
    p(0, 1, 7'h22, 3, 2);
    p(0, 1, 7'h22, 0, 2);
    p(0, 1, 7'h33, 4, 2);
`ifdef LOCK_LOCKOUT_EN
    press(1'b0, 1'b1, 7'h33, 1'b1, 5, 3, at_e);
    push(0, 0, at_e + LCK);
    check("lockout_flag", lockout, 1);
    check_blink("lockout_blink", 40, 1'b1);
    pn(0, 1, 7'h5A);
    pn(1, 0, 7'h5A);
    while (cyc <= at_e + LCK + 4) @(posedge clk);
    #1;
    check("fails_after_lockout", fails, 0);
    // lock out again, then reset in the middle of it
    p(0, 1, 7'h01, 4, 0);
    p(0, 1, 7'h01, 3, 1);
    p(0, 1, 7'h01, 0, 1);
    p(0, 1, 7'h01, 4, 1);
    p(0, 1, 7'h01, 3, 2);
    p(0, 1, 7'h01, 0, 2);
    p(0, 1, 7'h01, 4, 2);
    p(0, 1, 7'h01, 5, 3);
    repeat (30) @(posedge clk);
    do_reset();
`else
    p(0, 1, 7'h33, 3, 3);
    p(0, 1, 7'h33, 0, 3);
    p(0, 1, 7'h44, 4, 3);
    p(0, 1, 7'h44, 3, 3);
    check("no_lockout_flag", lockout, 0);
    do_reset();
`endif
    @(negedge clk);
    check("rst2_state", state, 0);
    check("rst2_fails", fails, 0);
    check("rst2_lockout", lockout, 0);
    check("rst2_opened", opened, 0);
    repeat (6) @(posedge clk);

    // password back to 0x00 after reset
    p(0, 1, 7'h00, 4, 0);
    p(0, 1, 7'h00, 2, 0);

    // simultaneous check+enter in OPENED: check wins
    p(1, 1, 7'h00, 1, 0);
    p(0, 1, 7'h7F, 0, 0);
    p(0, 1, 7'h00, 4, 0);
    p(0, 1, 7'h00, 2, 0);
    p(0, 1, 7'h00, 0, 0);

    // enter held across reset release must not produce a press
    @(posedge clk); #1;
    btn_enter = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    btn_enter = 1'b0;
    repeat (12) @(posedge clk);
    check("held_through_reset", state, 0);
    p(0, 1, 7'h00, 4, 0);

    repeat (5) @(posedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
